// File: rtl/orbit_pkg.sv
// Shared definitions for the orbit transmit-window scheduler:
// FSM state encoding, requester indices and parameter defaults.
package orbit_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARMUP = 3'd1,
        ARB    = 3'd2,
        GRANT  = 3'd3,
        GUARD  = 3'd4
    } state_t;

    localparam logic [1:0] BEACON  = 2'd0;
    localparam logic [1:0] SCIENCE = 2'd1;
    localparam logic [1:0] HK      = 2'd2;
    localparam logic [1:0] NONE    = 2'd3;

    localparam int SLOT_TICKS_DEF   = 50;
    localparam int GUARD_TICKS_DEF  = 5;
    localparam int WARMUP_TICKS_DEF = 10;

    localparam int CNT_W = 16;

    // Binary index of a one-hot grant vector, NONE when empty.
    function automatic logic [1:0] id_of(input logic [2:0] oh);
        logic [1:0] id;
        id = NONE;
        if (oh[0])
            id = BEACON;
        else if (oh[1])
            id = SCIENCE;
        else if (oh[2])
            id = HK;
        return id;
    endfunction

    // Round-robin successor of a requester index (mod 3).
    function automatic logic [1:0] next_ptr(input logic [1:0] id);
        logic [1:0] nxt;
        nxt = (id >= HK) ? BEACON : id + 2'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational 3-way round-robin arbiter.
// Ports: req (3 request levels), rr_ptr (search start index),
//        winner (one-hot or zero), valid (any request present).
module rr_arbiter3
    import orbit_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic [2:0] winner,
    output logic       valid
);

    logic [1:0] idx;
    logic       found;

    // Walk the three requesters starting at rr_ptr; first hit wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(rr_ptr) + k) % 3);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/tx_window_scheduler.sv
// Transmit-window scheduler: powers the radio while the orbit window
// is open and grants one requester at a time in round-robin order.
// Ports: clk, reset (sync, active-high), tx_window, req[2:0] in;
//        radio_on, grant[2:0], active_id[1:0], slot_timeout out.
module tx_window_scheduler
    import orbit_pkg::*;
#(
    parameter int SLOT_TICKS   = SLOT_TICKS_DEF,
    parameter int GUARD_TICKS  = GUARD_TICKS_DEF,
    parameter int WARMUP_TICKS = WARMUP_TICKS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_window,
    input  logic [2:0] req,
    output logic       radio_on,
    output logic [2:0] grant,
    output logic [1:0] active_id,
    output logic       slot_timeout
);

    localparam logic [CNT_W-1:0] SLOT_LD   = CNT_W'(SLOT_TICKS);
    localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_TICKS);
    localparam logic [CNT_W-1:0] WARMUP_LD = CNT_W'(WARMUP_TICKS);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [2:0]       win_q, win_d;

    logic             radio_on_d;
    logic [2:0]       grant_d;
    logic [1:0]       active_id_d;
    logic             slot_timeout_d;

    logic [2:0]       arb_winner;
    logic             arb_valid;

    rr_arbiter3 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    // Next state, counter and pointer. A closed window beats every
    // other exit, so a drop on the last slot cycle gives no timeout.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rr_ptr_d       = rr_ptr_q;
        win_d          = win_q;
        slot_timeout_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_window) begin
                    state_d = WARMUP;
                    cnt_d   = WARMUP_LD;
                end
            end

            WARMUP: begin
                if (!tx_window) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 1) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ARB: begin
                if (!tx_window) begin
                    state_d = IDLE;
                end else if (arb_valid) begin
                    state_d = GRANT;
                    win_d   = arb_winner;
                    cnt_d   = SLOT_LD;
                end
            end

            GRANT: begin
                if (!tx_window) begin
                    state_d = IDLE;
                    win_d   = '0;
                    cnt_d   = '0;
                end else if ((req & win_q) == 3'b000) begin
                    state_d  = GUARD;
                    win_d    = '0;
                    cnt_d    = GUARD_LD;
                    rr_ptr_d = next_ptr(id_of(win_q));
                end else if (cnt_q <= 1) begin
                    state_d        = GUARD;
                    win_d          = '0;
                    cnt_d          = GUARD_LD;
                    rr_ptr_d       = next_ptr(id_of(win_q));
                    slot_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            GUARD: begin
                if (!tx_window) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= 1) begin
                    state_d = ARB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                win_d   = '0;
            end
        endcase

        // Outputs follow the state being entered so they are registered.
        radio_on_d  = (state_d != IDLE);
        grant_d     = (state_d == GRANT) ? win_d : 3'b000;
        active_id_d = id_of(grant_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_ptr_q     <= BEACON;
            win_q        <= '0;
            radio_on     <= 1'b0;
            grant        <= '0;
            active_id    <= NONE;
            slot_timeout <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            radio_on     <= radio_on_d;
            grant        <= grant_d;
            active_id    <= active_id_d;
            slot_timeout <= slot_timeout_d;
        end
    end

endmodule

// File: tb/tb_tx_window_scheduler.sv
// Self-checking bench for tx_window_scheduler: timestamp-based model
// compared every cycle, plus directed literal checkpoints.
module tb_tx_window_scheduler;

    localparam int SLOT   = 50;
    localparam int GUARDT = 5;
    localparam int WARM   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_window;
    logic [2:0] req;
    logic       radio_on;
    logic [2:0] grant;
    logic [1:0] active_id;
    logic       slot_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;

    tx_window_scheduler #(
        .SLOT_TICKS   (SLOT),
        .GUARD_TICKS  (GUARDT),
        .WARMUP_TICKS (WARM)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_window    (tx_window),
        .req          (req),
        .radio_on     (radio_on),
        .grant        (grant),
        .active_id    (active_id),
        .slot_timeout (slot_timeout)
    );

    always #5 clk = ~clk;

    // Model: the window session, the cycle from which arbitration is
    // allowed, the current holder and when its grant began.
    int  mc = 0;
    bit  m_init = 0;
    bit  m_on = 0;
    int  m_cur = -1;
    int  m_gs = 0;
    int  m_arb = 0;
    int  m_ptr = 0;
    bit  m_pulse = 0;

    task automatic end_grant(input int c);
        m_ptr = (m_cur + 1) % 3;
        m_arb = c + 1 + GUARDT;
        m_cur = -1;
    endtask

    always @(posedge clk) begin
        logic       rs;
        logic       tw;
        logic [2:0] rq;
        logic [6:0] exp_v;
        logic [6:0] got_v;
        int         c;
        rs = reset;
        tw = tx_window;
        rq = req;
        c  = mc;
        mc++;
        m_pulse = 0;
        if (rs) begin
            m_init = 1;
            m_on   = 0;
            m_cur  = -1;
            m_ptr  = 0;
        end else if (!m_on) begin
            if (tw) begin
                m_on  = 1;
                m_cur = -1;
                m_arb = c + 1 + WARM;
            end
        end else if (!tw) begin
            m_on  = 0;
            m_cur = -1;
        end else if (m_cur >= 0) begin
            if (!rq[m_cur]) begin
                end_grant(c);
            end else if (c - m_gs + 1 == SLOT) begin
                m_pulse = 1;
                end_grant(c);
            end
        end else if (c >= m_arb && rq != 3'b000) begin
            for (int k = 0; k < 3; k++) begin
                if (m_cur < 0 && rq[(m_ptr + k) % 3])
                    m_cur = (m_ptr + k) % 3;
            end
            m_gs = c + 1;
        end
        #1;
        if (m_init) begin
            exp_v = {m_on,
                     (m_cur >= 0) ? 3'(1 << m_cur) : 3'b000,
                     (m_cur >= 0) ? 2'(m_cur) : 2'd3,
                     m_pulse};
            got_v = {radio_on, grant, active_id, slot_timeout};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL model cyc=%0d got r=%b g=%b id=%0d to=%b want r=%b g=%b id=%0d to=%b",
                         c + 1, got_v[6], got_v[5:3], got_v[2:1], got_v[0],
                         exp_v[6], exp_v[5:3], exp_v[2:1], exp_v[0]);
            end
        end
    end

    // Literal checkpoint: {radio_on, grant, active_id, slot_timeout}.
    task automatic chk(input string name, input logic [6:0] exp_v);
        logic [6:0] got_v;
        got_v = {radio_on, grant, active_id, slot_timeout};
        n_tests++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0d got %b want %b", name, t, got_v, exp_v);
        end
    endtask

    task automatic go(input int n);
        while (t < n) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic hold_reset();
        reset     = 1'b1;
        tx_window = 1'b0;
        req       = 3'b000;
        repeat (2) @(negedge clk);
    endtask

    task automatic start(input logic tw, input logic [2:0] rq);
        reset     = 1'b0;
        tx_window = tw;
        req       = rq;
        t         = 0;
    endtask

    localparam logic [6:0] OFF    = 7'b0_000_11_0;
    localparam logic [6:0] ON_IDL = 7'b1_000_11_0;
    localparam logic [6:0] TMO    = 7'b1_000_11_1;
    localparam logic [6:0] G_B    = 7'b1_001_00_0;
    localparam logic [6:0] G_S    = 7'b1_010_01_0;
    localparam logic [6:0] G_H    = 7'b1_100_10_0;

    initial begin
        reset     = 1'b1;
        tx_window = 1'b0;
        req       = 3'b000;

        // Single science requester, full slot then timeout.
        hold_reset();
        start(1'b1, 3'b010);
        chk("reset_state", OFF);
        go(1);   chk("warmup_on", ON_IDL);
        go(11);  chk("arb_cycle", ON_IDL);
        go(12);  chk("first_grant", G_S);
        go(61);  chk("last_grant", G_S);
        go(62);  chk("timeout_pulse", TMO);
        go(63);  chk("pulse_one_cycle", ON_IDL);

        // All requesting: round-robin rotation with guard gaps.
        hold_reset();
        start(1'b1, 3'b111);
        go(12);  chk("rr_beacon", G_B);
        go(61);  chk("rr_beacon_end", G_B);
        go(62);  chk("rr_to1", TMO);
        go(67);  chk("rr_arb_gap", ON_IDL);
        go(68);  chk("rr_science", G_S);
        go(118); chk("rr_to2", TMO);
        go(124); chk("rr_hk", G_H);
        go(174); chk("rr_to3", TMO);
        go(180); chk("rr_wrap", G_B);

        // Early release: no pulse, search resumes at science.
        hold_reset();
        start(1'b1, 3'b001);
        go(19);  chk("rel_before", G_B);
        req = 3'b110;
        go(20);  chk("rel_guard", ON_IDL);
        go(25);  chk("rel_arb", ON_IDL);
        go(26);  chk("rel_next", G_S);

        // Window drop at grant cycle 20, then reopen.
        hold_reset();
        start(1'b1, 3'b010);
        go(31);  chk("drop_pre", G_S);
        tx_window = 1'b0;
        go(32);  chk("drop_off", OFF);
        go(34);  chk("drop_stay", OFF);
        tx_window = 1'b1;
        go(35);  chk("reopen_warm", ON_IDL);
        go(45);  chk("reopen_arb", ON_IDL);
        go(46);  chk("reopen_grant", G_S);

        // Reset mid-grant clears rr_ptr.
        hold_reset();
        start(1'b1, 3'b111);
        go(68);  chk("mid_pre", G_S);
        go(80);
        reset = 1'b1;
        req   = 3'b100;
        go(81);  chk("mid_reset", OFF);
        @(negedge clk);
        start(1'b1, 3'b111);
        go(11);  chk("mid_arb", ON_IDL);
        go(12);  chk("mid_ptr0", G_B);

        // Drop on the last slot cycle beats the timeout.
        hold_reset();
        start(1'b1, 3'b001);
        go(61);  chk("last_pre", G_B);
        tx_window = 1'b0;
        go(62);  chk("last_drop", OFF);
        go(63);  chk("last_idle", OFF);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tx_window_scheduler.md
TX_WINDOW_SCHEDULER -- requirements
Module: tx_window_scheduler

Interface
REQ-001 SHALL have parameter SLOT_TICKS, default 50, maximum grant length in clk cycles (5 s at 10 Hz); legal range 1..65535.
REQ-002 SHALL have parameter GUARD_TICKS, default 5, idle gap between grants in clk cycles; legal range 1..65535.
REQ-003 SHALL have parameter WARMUP_TICKS, default 10, radio power-up delay in clk cycles; legal range 1..65535.
REQ-004 SHALL have port clk  input  1  single system clock (10 Hz tick domain); all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_window  input  1  level from the orbit transmit-window timer; 1 = transmission permitted.
REQ-007 SHALL have port req  input  3  level requests: bit0 beacon, bit1 science, bit2 housekeeping.
REQ-008 SHALL have port radio_on  output  1  transmitter power enable.
REQ-009 SHALL have port grant  output  3  one-hot or zero grant to requesters.
REQ-010 SHALL have port active_id  output  2  index of granted requester; 2'd3 when no grant.
REQ-011 SHALL have port slot_timeout  output  1  one-cycle pulse when a grant ends by SLOT_TICKS expiry.

Function
REQ-012 SHALL implement states IDLE, WARMUP, ARB, GRANT, GUARD; all outputs registered.
REQ-013 IDLE: radio_on=0, grant=0; tx_window=1 -> WARMUP, counter loaded WARMUP_TICKS.
REQ-014 WARMUP: radio_on=1, grant=0; counter decrements each cycle; occupies exactly WARMUP_TICKS cycles, then ARB.
REQ-015 ARB: radio_on=1; any req bit set -> GRANT with winner chosen round-robin starting at rr_ptr; no req -> remain ARB indefinitely.
REQ-016 grant SHALL assert on the edge ending the ARB cycle in which req was sampled (one-cycle arbitration latency).
REQ-017 GRANT: grant held exactly one-hot; ends -> GUARD when granted req bit is 0 (sampled) or after SLOT_TICKS grant cycles, whichever first.
REQ-018 Timeout end SHALL pulse slot_timeout for one cycle coincident with first GUARD cycle; release end SHALL NOT pulse.
REQ-019 On leaving GRANT, rr_ptr SHALL become (granted index + 1) mod 3; rr_ptr reset value 0.
REQ-020 Requests for non-granted bits during GRANT/GUARD SHALL be ignored until next ARB; no queuing.
REQ-021 GUARD: grant=0, radio_on=1, exactly GUARD_TICKS cycles, then ARB; gap between consecutive grants = GUARD_TICKS+1 cycles.
REQ-022 tx_window=0 sampled in any non-IDLE state SHALL force IDLE on that edge: grant, radio_on cleared next cycle, no slot_timeout pulse, rr_ptr retained.
REQ-023 tx_window dropping and slot expiry on same cycle: window drop wins, no slot_timeout.
REQ-024 Counters SHALL be 16 bits unsigned, never wrap: load N, decrement to 1, transition on 1.
REQ-025 active_id SHALL equal binary index of set grant bit, 2'd3 otherwise, same cycle as grant.

Reset
REQ-026 reset=1 at a clk edge SHALL set state IDLE, radio_on=0, grant=0, active_id=2'd3, slot_timeout=0, rr_ptr=0, counter=0; overrides all inputs including mid-grant.
REQ-027 First cycle after reset release SHALL evaluate tx_window normally (IDLE behaviour).

Structure
REQ-028 State encoding, requester index constants (BEACON=0, SCIENCE=1, HK=2, NONE=3) and parameter defaults SHALL reside in shared package orbit_pkg.
REQ-029 Round-robin selection SHALL be a combinational sub-module rr_arbiter3 (inputs req, rr_ptr; outputs one-hot winner, valid).

Verification
REQ-030 Reset, tx_window=1 at cycle 0, req=3'b010 held -> radio_on=1 from cycle 1, grant=3'b010 from cycle 12, active_id=1.
REQ-031 req=3'b111 held, window open -> grant sequence 001,010,100,001; each 50 cycles, 6 zero-grant cycles between, slot_timeout pulse at each end.
REQ-032 grant=3'b001, req[0] dropped after 7 grant cycles -> GUARD next cycle, no slot_timeout, next winner searched from bit1.
REQ-033 tx_window dropped at grant cycle 20 -> grant=0, radio_on=0 next cycle; reopen -> full 10-cycle WARMUP repeated.
REQ-034 reset asserted mid-GRANT with req=3'b100 -> all outputs to reset values next cycle, rr_ptr=0, re-arbitration after WARMUP.
REQ-035 tx_window drop on last grant cycle (SLOT_TICKS) -> IDLE, slot_timeout stays 0.
